// File: rtl/matrix_mac_sequencer_if.sv
// Control bundle between the MAC sequencer (master) and its job, operand and result peers (slave).
`timescale 1ns/1ps
interface matrix_mac_sequencer_if #(
  parameter int PASS_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [PASS_WIDTH-1:0] cmd_passes;
  logic                  op_valid;
  logic                  op_ready;
  logic                  mac_clear;
  logic                  mac_enable;
  logic                  res_valid;
  logic                  res_ready;
  logic                  busy;
  logic [PASS_WIDTH-1:0] pass_count;

  modport master (
    input  cmd_valid, cmd_passes, op_valid, res_ready,
    output cmd_ready, op_ready, mac_clear, mac_enable, res_valid, busy, pass_count
  );

  modport slave (
    output cmd_valid, cmd_passes, op_valid, res_ready,
    input  cmd_ready, op_ready, mac_clear, mac_enable, res_valid, busy, pass_count
  );
endinterface

// File: rtl/matrix_mac_sequencer.sv
// 4x4 MAC job sequencer: clear, one enable per accepted tile pair, drain MAC_LATENCY, then result handshake.
// Cmd fire to res_valid is 2+P+MAC_LATENCY cycles at full rate; stalls on op_valid low and holds res_valid until res_ready.
`timescale 1ns/1ps
module matrix_mac_sequencer #(
  parameter int PASS_WIDTH  = 8,
  parameter int MAC_LATENCY = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  matrix_mac_sequencer_if.master  ctrl_io
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [3:0] DRAIN_LOAD = 4'(MAC_LATENCY);

  state_e                state_q, state_d;
  logic [PASS_WIDTH-1:0] passes_q, passes_d;
  logic [PASS_WIDTH-1:0] pass_count_q, pass_count_d;
  logic [3:0]            drain_q, drain_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      passes_q     <= '0;
      pass_count_q <= '0;
      drain_q      <= '0;
    end else begin
      state_q      <= state_d;
      passes_q     <= passes_d;
      pass_count_q <= pass_count_d;
      drain_q      <= drain_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    passes_d     = passes_q;
    pass_count_d = pass_count_q;
    drain_d      = drain_q;
    unique case (state_q)
      IDLE: begin
        if (ctrl_io.cmd_valid) begin
          passes_d     = ctrl_io.cmd_passes;
          pass_count_d = '0;
          state_d      = CLEAR;
        end
      end
      CLEAR: begin
        state_d = (passes_q == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        if (ctrl_io.op_valid) begin
          pass_count_d = pass_count_q + 1'b1;
          // Comparing the incremented count avoids the passes_q-1 underflow case entirely.
          if ((pass_count_q + 1'b1) == passes_q) begin
            if (MAC_LATENCY > 0) begin
              state_d = DRAIN;
              drain_d = DRAIN_LOAD;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      DRAIN: begin
        drain_d = drain_q - 1'b1;
        if (drain_q <= 4'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (ctrl_io.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctrl_io.cmd_ready  = (state_q == IDLE);
    ctrl_io.op_ready   = (state_q == ACCUM);
    ctrl_io.mac_clear  = (state_q == CLEAR);
    ctrl_io.mac_enable = (state_q == ACCUM) && ctrl_io.op_valid;
    ctrl_io.res_valid  = (state_q == DONE);
    ctrl_io.busy       = (state_q != IDLE);
    ctrl_io.pass_count = pass_count_q;
  end

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Scoreboard bench for matrix_mac_sequencer: jobs push expected results, a negedge monitor checks handshakes and timing.
`timescale 1ns/1ps
module tb_matrix_mac_sequencer;

  localparam int PW  = 8;
  localparam int LAT = 1;

  typedef struct {
    int passes;
    bit full;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  matrix_mac_sequencer_if #(.PASS_WIDTH(PW)) bus ();

  matrix_mac_sequencer #(.PASS_WIDTH(PW), .MAC_LATENCY(LAT)) dut (
    .clock   (clock),
    .reset   (reset),
    .ctrl_io (bus)
  );

  int   tests  = 0;
  int   fails  = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, i.e. the values the next rising edge will act on.
  int   cyc = 0, enables = 0, last_en = 0, clear_cyc = 0, cmd_cyc = 0, res_fire_cyc = 0, b2b_res = 0;
  bit   b2b_mode = 1'b0, prev_clear = 1'b0, prev_rv = 1'b0, prev_rr = 1'b0;
  exp_t mon_e;

  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      enables    = 0;
      prev_clear = 1'b0;
      prev_rv    = 1'b0;
      prev_rr    = 1'b0;
    end else begin
      if (bus.mac_clear) begin
        check("clear_single", int'(prev_clear), 0);
        enables   = 0;
        clear_cyc = cyc;
      end
      if (bus.op_valid) check("enable_follows_op", int'(bus.mac_enable), int'(bus.op_ready));
      if (bus.mac_enable) begin
        check("enable_needs_op", int'(bus.op_valid), 1);
        enables++;
        last_en = cyc;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        check("cmd_not_busy", int'(bus.busy), 0);
        if (b2b_mode && b2b_res > 0) check("b2b_gap", cyc - res_fire_cyc, 1);
        cmd_cyc = cyc;
      end
      if (prev_rv && !prev_rr) check("res_hold", int'(bus.res_valid), 1);
      if (bus.res_valid && !prev_rv) begin
        if (exp_q.size() == 0) begin
          check("unexpected_res", exp_q.size(), 1);
        end else begin
          mon_e = exp_q[0];
          if (mon_e.passes == 0) check("zero_latency", cyc - clear_cyc, 1);
          else                   check("drain_latency", cyc - last_en, 1 + LAT);
          if (mon_e.full)        check("job_latency", cyc - cmd_cyc, 2 + mon_e.passes + LAT);
        end
      end
      if (bus.res_valid && bus.res_ready && exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("pass_count", int'(bus.pass_count), mon_e.passes);
        check("enable_count", enables, mon_e.passes);
        res_fire_cyc = cyc;
        if (b2b_mode) b2b_res++;
      end
      prev_clear = bus.mac_clear;
      prev_rv    = bus.res_valid;
      prev_rr    = bus.res_ready;
    end
  end

  // opm: 0 op_valid always, 1 random, 2 pattern 1,0,0,1,0,1. rrm: 0 always, 1 random, 2 low for 5 cycles.
  task automatic run_job(input int p, input int opm, input int rrm);
    int n, k, rv_seen, bound;
    bit done;
    bit pat[6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_q.push_back('{p, (opm == 0) && (p > 0)});
    bus.cmd_valid  = 1'b1;
    bus.cmd_passes = PW'(p);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.cmd_ready && n < 100);
    check("cmd_accept", int'(bus.cmd_ready), 1);
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    done    = 1'b0;
    rv_seen = 0;
    bound   = 4 * p + 100;
    k       = 0;
    while (!done && k < bound) begin
      case (opm)
        0:       bus.op_valid = 1'b1;
        1:       bus.op_valid = ($urandom_range(0, 3) != 0);
        default: bus.op_valid = pat[k % 6];
      endcase
      case (rrm)
        0:       bus.res_ready = 1'b1;
        1:       bus.res_ready = $urandom_range(0, 1) != 0;
        default: bus.res_ready = (rv_seen >= 5);
      endcase
      @(negedge clock);
      if (bus.res_valid) rv_seen++;
      if (bus.res_valid && bus.res_ready) done = 1'b1;
      @(posedge clock); #1;
      k++;
    end
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b0;
    check("job_done", int'(done), 1);
    @(negedge clock);
    check("idle_after_res", int'(bus.cmd_ready), 1);
    check("count_holds", int'(bus.pass_count), p);
    @(posedge clock); #1;
  endtask

  initial begin
    int n, k;
    bus.cmd_valid  = 1'b0;
    bus.cmd_passes = '0;
    bus.op_valid   = 1'b0;
    bus.res_ready  = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    @(negedge clock);
    check("rst_cmd_ready", int'(bus.cmd_ready), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_op_ready", int'(bus.op_ready), 0);
    check("rst_mac_clear", int'(bus.mac_clear), 0);
    check("rst_res_valid", int'(bus.res_valid), 0);
    check("rst_pass_count", int'(bus.pass_count), 0);
    @(posedge clock); #1;
    bus.op_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("idle_no_enable", int'(bus.mac_enable), 0);
    end
    @(posedge clock); #1;
    bus.op_valid = 1'b0;

    run_job(4, 0, 0);
    run_job(3, 2, 2);
    run_job(0, 0, 0);
    run_job(1, 0, 2);

    // Abandon a 10-pass job after 5 fires; no result may appear.
    bus.cmd_valid  = 1'b1;
    bus.cmd_passes = PW'(10);
    bus.op_valid   = 1'b1;
    n = 0;
    k = 0;
    while (n < 5 && k < 100) begin
      @(negedge clock);
      if (bus.mac_enable) n++;
      if (bus.cmd_ready) begin
        @(posedge clock); #1;
        bus.cmd_valid = 1'b0;
      end else begin
        @(posedge clock); #1;
      end
      k++;
    end
    check("mid_fires", n, 5);
    reset        = 1'b0;
    bus.op_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_cmd_ready", int'(bus.cmd_ready), 1);
    check("midrst_pass_count", int'(bus.pass_count), 0);
    check("midrst_res_valid", int'(bus.res_valid), 0);
    @(posedge clock); #1;
    run_job(2, 0, 0);

    // Back-to-back: cmd_valid held across three jobs of 2 passes.
    for (int i = 0; i < 3; i++) exp_q.push_back('{2, 1'b1});
    b2b_mode       = 1'b1;
    bus.cmd_passes = PW'(2);
    bus.cmd_valid  = 1'b1;
    bus.op_valid   = 1'b1;
    bus.res_ready  = 1'b1;
    n = 0;
    k = 0;
    while (n < 3 && k < 200) begin
      @(negedge clock);
      if (bus.res_valid && bus.res_ready) n++;
      @(posedge clock); #1;
      k++;
    end
    bus.cmd_valid = 1'b0;
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b0;
    check("b2b_jobs", n, 3);
    check("b2b_gaps_seen", b2b_res, 3);
    b2b_mode = 1'b0;
    @(posedge clock); #1;

    for (int j = 0; j < 20; j++) begin
      run_job(int'($urandom_range(0, 20)), 1, 1);
    end
    run_job(255, 1, 1);
    run_job(255, 0, 0);

    repeat (5) @(negedge clock);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d failed so far", fails);
    $fatal(1);
  end

endmodule
